// File: rtl/vram_arbiter_if.sv
// Signal bundle between the VRAM requesters (PPU, OAM DMA, CPU), the arbiter and the VRAM pins.
interface vram_arbiter_if;
  // Requesters raise *_req and hold it with stable address/data until their one-cycle *_ack pulse;
  // *_rdata is valid while *_ack=1, and blocked accompanies an ack for a request refused in mode 3.
  logic        ppu_req;
  logic [12:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        ppu_ack;
  logic        dma_req;
  logic [12:0] dma_addr;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic        cpu_req;
  logic        cpu_wr;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        mode3;
  logic [12:0] vram_a;
  logic [7:0]  vram_dout;
  logic        vram_doe;
  logic [7:0]  vram_din;
  logic        vram_cs_n;
  logic        vram_oe_n;
  logic        vram_wr_n;
  logic        blocked;

  modport slave (
    input  ppu_req, ppu_addr, dma_req, dma_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
           mode3, vram_din,
    output ppu_rdata, ppu_ack, dma_rdata, dma_ack, cpu_rdata, cpu_ack, vram_a, vram_dout,
           vram_doe, vram_cs_n, vram_oe_n, vram_wr_n, blocked
  );

  modport master (
    output ppu_req, ppu_addr, dma_req, dma_addr, cpu_req, cpu_wr, cpu_addr, cpu_wdata,
           mode3, vram_din,
    input  ppu_rdata, ppu_ack, dma_rdata, dma_ack, cpu_rdata, cpu_ack, vram_a, vram_dout,
           vram_doe, vram_cs_n, vram_oe_n, vram_wr_n, blocked
  );
endinterface

// File: rtl/vram_arbiter.sv
// Fixed-priority (PPU > DMA > CPU) VRAM arbiter running two-cycle ADDR/DATA accesses,
// with CPU/DMA lockout during PPU pixel transfer (mode 3).
module vram_arbiter (
  input  logic          clk,
  input  logic          nreset,
  vram_arbiter_if.slave bus,
  output logic [1:0]    o_dbg_state
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ADDR  = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] OWN_PPU = 2'd0;
  localparam logic [1:0] OWN_DMA = 2'd1;
  localparam logic [1:0] OWN_CPU = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  r_owner;
  logic        r_op_wr;
  logic [12:0] r_vram_a;
  logic [7:0]  r_vram_dout;
  logic        r_cs_n;
  logic        r_oe_n;
  logic        r_wr_n;
  logic        r_doe;
  logic        r_ppu_ack;
  logic        r_dma_ack;
  logic        r_cpu_ack;
  logic        r_blocked;
  logic [7:0]  r_ppu_rdata;
  logic [7:0]  r_dma_rdata;
  logic [7:0]  r_cpu_rdata;

  logic        w_in_data;
  logic        w_arb;
  logic        w_ppu_cand;
  logic        w_dma_cand;
  logic        w_cpu_cand;
  logic        w_win_valid;
  logic [1:0]  w_win_id;
  logic [12:0] w_win_addr;
  logic        w_win_wr;
  logic        w_lock;
  logic        w_grant;
  logic        w_next_wr;
  logic [1:0]  w_next_state;

  assign w_in_data = (r_state == S_DATA);
  assign w_arb     = (r_state == S_IDLE) || w_in_data;

  // The owner finishing in DATA still holds req until its ack, so it is excluded like an acked requester.
  assign w_ppu_cand = bus.ppu_req && !r_ppu_ack && !(w_in_data && (r_owner == OWN_PPU));
  assign w_dma_cand = bus.dma_req && !r_dma_ack && !(w_in_data && (r_owner == OWN_DMA));
  assign w_cpu_cand = bus.cpu_req && !r_cpu_ack && !(w_in_data && (r_owner == OWN_CPU));

  always_comb begin
    w_win_valid = 1'b1;
    w_win_id    = OWN_PPU;
    w_win_addr  = bus.ppu_addr;
    w_win_wr    = 1'b0;
    if (w_ppu_cand) begin
      w_win_id   = OWN_PPU;
    end else if (w_dma_cand) begin
      w_win_id   = OWN_DMA;
      w_win_addr = bus.dma_addr;
    end else if (w_cpu_cand) begin
      w_win_id   = OWN_CPU;
      w_win_addr = bus.cpu_addr;
      w_win_wr   = bus.cpu_wr;
    end else begin
      w_win_valid = 1'b0;
    end
  end

  assign w_lock    = w_arb && w_win_valid && bus.mode3 && (w_win_id != OWN_PPU);
  assign w_grant   = w_arb && w_win_valid && !w_lock;
  assign w_next_wr = w_grant ? w_win_wr : r_op_wr;

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_ADDR:  w_next_state = S_DATA;
      default: w_next_state = w_grant ? S_ADDR : S_IDLE;
    endcase
  end

  // Strobes are computed from the next state so they are registered and align with r_state.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state     <= S_IDLE;
      r_owner     <= OWN_PPU;
      r_op_wr     <= 1'b0;
      r_vram_a    <= 13'h0000;
      r_vram_dout <= 8'h00;
      r_cs_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_wr_n      <= 1'b1;
      r_doe       <= 1'b0;
      r_ppu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_blocked   <= 1'b0;
      r_ppu_rdata <= 8'h00;
      r_dma_rdata <= 8'h00;
      r_cpu_rdata <= 8'h00;
    end else begin
      r_state <= w_next_state;
      if (w_grant) begin
        r_owner  <= w_win_id;
        r_op_wr  <= w_win_wr;
        r_vram_a <= w_win_addr;
        if (w_win_wr) r_vram_dout <= bus.cpu_wdata;
      end
      r_cs_n    <= (w_next_state == S_IDLE);
      r_oe_n    <= (w_next_state == S_IDLE) || w_next_wr;
      r_doe     <= (w_next_state != S_IDLE) && w_next_wr;
      r_wr_n    <= !((w_next_state == S_DATA) && w_next_wr);
      r_ppu_ack <= w_in_data && (r_owner == OWN_PPU);
      r_dma_ack <= (w_in_data && (r_owner == OWN_DMA)) || (w_lock && (w_win_id == OWN_DMA));
      r_cpu_ack <= (w_in_data && (r_owner == OWN_CPU)) || (w_lock && (w_win_id == OWN_CPU));
      r_blocked <= w_lock;
      if (w_in_data && !r_op_wr) begin
        if (r_owner == OWN_PPU) r_ppu_rdata <= bus.vram_din;
        if (r_owner == OWN_DMA) r_dma_rdata <= bus.vram_din;
        if (r_owner == OWN_CPU) r_cpu_rdata <= bus.vram_din;
      end
      if (w_lock && (w_win_id == OWN_DMA)) r_dma_rdata <= 8'hFF;
      if (w_lock && (w_win_id == OWN_CPU)) r_cpu_rdata <= 8'hFF;
    end
  end

  assign bus.vram_a    = r_vram_a;
  assign bus.vram_dout = r_vram_dout;
  assign bus.vram_doe  = r_doe;
  assign bus.vram_cs_n = r_cs_n;
  assign bus.vram_oe_n = r_oe_n;
  assign bus.vram_wr_n = r_wr_n;
  assign bus.ppu_ack   = r_ppu_ack;
  assign bus.dma_ack   = r_dma_ack;
  assign bus.cpu_ack   = r_cpu_ack;
  assign bus.blocked   = r_blocked;
  assign bus.ppu_rdata = r_ppu_rdata;
  assign bus.dma_rdata = r_dma_rdata;
  assign bus.cpu_rdata = r_cpu_rdata;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: reset, CPU read/write, lockout, priority chain, mid-access events.
`timescale 1ns/1ps
module tb_vram_arbiter;
  logic       clk = 1'b0;
  logic       nreset;
  logic [1:0] dbg_state;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] mem [0:8191];
  logic       mem_ready = 1'b0;
  logic [7:0] rd_data;
  logic       rd_ok;

  vram_arbiter_if bus();

  vram_arbiter dut (
    .clk         (clk),
    .nreset      (nreset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // VRAM model: preloaded on the first edge, written at the edge closing a write strobe.
  assign bus.vram_din = (!bus.vram_cs_n && !bus.vram_oe_n) ? mem[bus.vram_a] : 8'h00;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
      mem[13'h1234] <= 8'hA5;
      mem[13'h0100] <= 8'h5A;
      mem_ready     <= 1'b1;
    end else if (!bus.vram_cs_n && !bus.vram_wr_n) begin
      mem[bus.vram_a] <= bus.vram_dout;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {bus.vram_cs_n, bus.vram_oe_n, bus.vram_wr_n, bus.vram_doe};
  endfunction

  function automatic logic [3:0] acks();
    return {bus.ppu_ack, bus.dma_ack, bus.cpu_ack, bus.blocked};
  endfunction

  task automatic cpu_read(input logic [12:0] addr, output logic [7:0] data, output logic ok);
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = addr;
    ok   = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (bus.cpu_ack) begin
        ok   = 1'b1;
        data = bus.cpu_rdata;
      end
    end
    bus.cpu_req = 1'b0;
  endtask

  logic        prio_cs  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [3:0]  prio_ack [8] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h4, 4'h0, 4'h2, 4'h0};
  logic [12:0] prio_a   [8] = '{13'h1234, 13'h1234, 13'h0010, 13'h0010,
                                13'h0100, 13'h0100, 13'h0100, 13'h0100};

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset        = 1'b0;
    bus.ppu_req   = 1'b0;
    bus.ppu_addr  = 13'h0;
    bus.dma_req   = 1'b0;
    bus.dma_addr  = 13'h0;
    bus.cpu_req   = 1'b0;
    bus.cpu_wr    = 1'b0;
    bus.cpu_addr  = 13'h0;
    bus.cpu_wdata = 8'h00;
    bus.mode3     = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_strobes", strobes(), 4'b1110);
    chk("rst_acks", acks(), 4'h0);
    chk("rst_addr_dout", {bus.vram_a, bus.vram_dout}, 21'h0);
    chk("rst_rdata", {bus.ppu_rdata, bus.dma_rdata, bus.cpu_rdata}, 24'h0);
    nreset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle_strobes", strobes(), 4'b1110);
      chk("idle_acks", acks(), 4'h0);
    end

    // CPU read of 0x1234
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 13'h1234;
    tick();
    chk("rd_addr_state", dbg_state, 2'd1);
    chk("rd_addr_a", bus.vram_a, 13'h1234);
    chk("rd_addr_strobes", strobes(), 4'b0010);
    chk("rd_addr_acks", acks(), 4'h0);
    tick();
    chk("rd_data_state", dbg_state, 2'd2);
    chk("rd_data_strobes", strobes(), 4'b0010);
    chk("rd_data_acks", acks(), 4'h0);
    tick();
    chk("rd_ack", acks(), 4'b0010);
    chk("rd_rdata", bus.cpu_rdata, 8'hA5);
    chk("rd_end_strobes", strobes(), 4'b1110);
    bus.cpu_req = 1'b0;
    tick();
    chk("rd_ack_pulse", acks(), 4'h0);

    // CPU write 0x3C to 0x0010
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 13'h0010;
    bus.cpu_wdata = 8'h3C;
    tick();
    chk("wr_addr_strobes", strobes(), 4'b0111);
    chk("wr_addr_bus", {bus.vram_a, bus.vram_dout}, {13'h0010, 8'h3C});
    tick();
    chk("wr_data_strobes", strobes(), 4'b0101);
    tick();
    chk("wr_ack", acks(), 4'b0010);
    chk("wr_end_strobes", strobes(), 4'b1110);
    chk("wr_rdata_hold", bus.cpu_rdata, 8'hA5);
    bus.cpu_req = 1'b0;
    bus.cpu_wr  = 1'b0;
    tick();
    cpu_read(13'h0010, rd_data, rd_ok);
    chk("wr_rb_ack", rd_ok, 1'b1);
    chk("wr_rb_data", rd_data, 8'h3C);
    tick();

    // Lockout: CPU write then DMA read in mode 3
    bus.mode3     = 1'b1;
    bus.cpu_req   = 1'b1;
    bus.cpu_wr    = 1'b1;
    bus.cpu_addr  = 13'h0010;
    bus.cpu_wdata = 8'h77;
    tick();
    chk("lk_cpu_acks", acks(), 4'b0011);
    chk("lk_cpu_rdata", bus.cpu_rdata, 8'hFF);
    chk("lk_cpu_strobes", strobes(), 4'b1110);
    bus.cpu_req = 1'b0;
    bus.cpu_wr  = 1'b0;
    tick();
    chk("lk_cpu_after", acks(), 4'h0);
    chk("lk_cpu_after_strobes", strobes(), 4'b1110);
    bus.dma_req  = 1'b1;
    bus.dma_addr = 13'h0010;
    tick();
    chk("lk_dma_acks", acks(), 4'b0101);
    chk("lk_dma_rdata", bus.dma_rdata, 8'hFF);
    chk("lk_dma_strobes", strobes(), 4'b1110);
    bus.dma_req = 1'b0;
    tick();
    chk("lk_dma_after", acks(), 4'h0);
    bus.mode3 = 1'b0;
    cpu_read(13'h0010, rd_data, rd_ok);
    chk("lk_rb_ack", rd_ok, 1'b1);
    chk("lk_rb_data", rd_data, 8'h3C);
    tick();

    // Priority and back-to-back: all three request on the same edge
    bus.ppu_req  = 1'b1;
    bus.ppu_addr = 13'h1234;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 13'h0010;
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 13'h0100;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("prio_cs_n", bus.vram_cs_n, prio_cs[c]);
      chk("prio_acks", acks(), prio_ack[c]);
      if (c < 6) chk("prio_vram_a", bus.vram_a, prio_a[c]);
      if (bus.ppu_ack) begin
        chk("prio_ppu_rdata", bus.ppu_rdata, 8'hA5);
        bus.ppu_req = 1'b0;
      end
      if (bus.dma_ack) begin
        chk("prio_dma_rdata", bus.dma_rdata, 8'h3C);
        bus.dma_req = 1'b0;
      end
      if (bus.cpu_ack) begin
        chk("prio_cpu_rdata", bus.cpu_rdata, 8'h5A);
        bus.cpu_req = 1'b0;
      end
    end
    bus.ppu_req = 1'b0;
    bus.dma_req = 1'b0;
    bus.cpu_req = 1'b0;
    tick();

    // mode3 rising during DATA does not abort the read
    bus.cpu_req  = 1'b1;
    bus.cpu_wr   = 1'b0;
    bus.cpu_addr = 13'h1234;
    tick();
    chk("m3_addr_state", dbg_state, 2'd1);
    tick();
    chk("m3_data_state", dbg_state, 2'd2);
    bus.mode3 = 1'b1;
    tick();
    chk("m3_acks", acks(), 4'b0010);
    chk("m3_rdata", bus.cpu_rdata, 8'hA5);
    bus.cpu_req = 1'b0;
    bus.mode3   = 1'b0;
    tick();

    // Reset pulse during ADDR: strobes drop without a clock edge, no ack follows
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 13'h0100;
    tick();
    chk("rstmid_addr_strobes", strobes(), 4'b0010);
    #2;
    nreset = 1'b0;
    #1;
    chk("rstmid_async_strobes", strobes(), 4'b1110);
    chk("rstmid_async_state", dbg_state, 2'd0);
    bus.cpu_req = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rstmid_no_ack", acks(), 4'h0);
    end
    chk("rstmid_rdata", bus.cpu_rdata, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
